// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared types and helpers for the local-port inject arbiter and its round-robin picker.
// Provides the flit width default when the surrounding NoC build has not defined one.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_local_inject_arbiter_pkg;

    typedef enum logic {
        NOC_ARB_ST_ARB = 1'b0,
        NOC_ARB_ST_PKT = 1'b1
    } noc_arb_state_e;

    localparam int NOC_ARB_STALL_W = 8;

    function automatic int noc_arb_ptr_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam int NOC_ARB_PTR_W = noc_arb_ptr_w(4);

endpackage

// File: rtl/noc_local_inject_arbiter_if.sv
// Bundle between the on-tile packet sources, the router local input port and the arbiter.
// master = sources/router side, slave = arbiter.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_local_inject_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = `Noc_Data_Width
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_is_header;
    logic [NUM_REQ-1:0]        req_is_tail;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_flit;
    logic                      out_is_header;
    logic                      out_is_tail;
    logic [NUM_REQ-1:0]        grant;
    logic                      timeout_err;

    modport master (
        output req_valid, req_flit, req_is_header, req_is_tail, out_ready,
        input  req_ready, out_valid, out_flit, out_is_header, out_is_tail, grant, timeout_err
    );

    modport slave (
        input  req_valid, req_flit, req_is_header, req_is_tail, out_ready,
        output req_ready, out_valid, out_flit, out_is_header, out_is_tail, grant, timeout_err
    );
endinterface

// File: rtl/noc_local_inject_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping at N-1.
// Kept generic so VC allocators can reuse it.
module noc_rr_picker
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = noc_arb_ptr_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);
    logic [PTR_W-1:0] scan;
    logic [PTR_W-1:0] win;
    logic             found;

    always_comb begin
        scan  = ptr_i;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[scan]) begin
                found = 1'b1;
                win   = scan;
            end
            scan = (scan == PTR_W'(N - 1)) ? '0 : scan + 1'b1;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (found) gnt_o[win] = 1'b1;
    end

    assign idx_o = win;
    assign any_o = found;

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Per-packet round-robin arbiter sharing one router local input port between NUM_REQ sources.
// Optional stall watchdog enabled by defining NOC_ARB_TIMEOUT_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_inject_arbiter
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = `Noc_Data_Width,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                       noc_clk,
    input logic                       noc_rst,
    noc_local_inject_arbiter_if.slave arb
);
    localparam int PTR_W = noc_arb_ptr_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("noc_local_inject_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    noc_arb_state_e   state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0] owner_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic             out_valid_q;
    logic             out_hdr_q;
    logic             out_tail_q;
    logic [DATA_W-1:0] out_flit_q;

    logic [DATA_W-1:0] flit_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign flit_arr[gi] = arb.req_flit[gi*DATA_W +: DATA_W];
    end

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    assign cand = arb.req_valid & arb.req_is_header;

    noc_rr_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i (cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    logic              in_pkt;
    logic              out_free;
    logic              own_valid;
    logic              own_hdr;
    logic              own_tail;
    logic [DATA_W-1:0] own_flit;
    logic              to_hit;
    logic              accept;
    logic              to_fire;
    logic              release_pkt;
    logic [PTR_W-1:0]  next_ptr;

    assign in_pkt      = (state_q == NOC_ARB_ST_PKT);
    assign out_free    = !out_valid_q || arb.out_ready;
    assign own_valid   = arb.req_valid[owner_q];
    assign own_hdr     = arb.req_is_header[owner_q];
    assign own_tail    = arb.req_is_tail[owner_q];
    assign own_flit    = flit_arr[owner_q];
    assign accept      = in_pkt && out_free && own_valid && !to_hit;
    assign to_fire     = in_pkt && out_free && to_hit;
    assign release_pkt = (accept && own_tail) || to_fire;
    assign next_ptr    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Once the watchdog has fired the owner is held off so the synthetic tail cannot race a real flit.
    assign arb.req_ready = grant_q & {NUM_REQ{in_pkt && out_free && !to_hit}};

`ifdef NOC_ARB_TIMEOUT_EN
    logic [NOC_ARB_STALL_W-1:0] stall_q;
    logic                       timeout_err_q;

    assign to_hit          = (stall_q == NOC_ARB_STALL_W'(TIMEOUT_CYC));
    assign arb.timeout_err = timeout_err_q;
`else
    assign to_hit          = 1'b0;
    assign arb.timeout_err = 1'b0;
`endif

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q     <= NOC_ARB_ST_ARB;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_hdr_q   <= 1'b0;
            out_tail_q  <= 1'b0;
            out_flit_q  <= '0;
`ifdef NOC_ARB_TIMEOUT_EN
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            if (out_free) begin
                out_valid_q <= accept || to_fire;
                if (accept) begin
                    out_flit_q <= own_flit;
                    out_hdr_q  <= own_hdr;
                    out_tail_q <= own_tail;
                end else if (to_fire) begin
                    out_flit_q <= '0;
                    out_hdr_q  <= 1'b0;
                    out_tail_q <= 1'b1;
                end
            end

            case (state_q)
                NOC_ARB_ST_ARB: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        owner_q <= pick_idx;
                        state_q <= NOC_ARB_ST_PKT;
                    end
                end
                NOC_ARB_ST_PKT: begin
                    if (release_pkt) begin
                        grant_q  <= '0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= NOC_ARB_ST_ARB;
                    end
                end
                default: state_q <= NOC_ARB_ST_ARB;
            endcase

`ifdef NOC_ARB_TIMEOUT_EN
            if (!in_pkt || accept || to_fire) begin
                stall_q <= '0;
            end else if (!own_valid && !to_hit) begin
                stall_q <= stall_q + 1'b1;
            end
            if (to_fire) timeout_err_q <= 1'b1;
`endif
        end
    end

    assign arb.out_valid     = out_valid_q;
    assign arb.out_flit      = out_flit_q;
    assign arb.out_is_header = out_hdr_q;
    assign arb.out_is_tail   = out_tail_q;
    assign arb.grant         = grant_q;

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed bench for noc_local_inject_arbiter: per-source flit queues feed the DUT,
// a monitor collects router-side transfers, and a linear sequence checks hand-derived results.
module tb_noc_local_inject_arbiter;
    import noc_local_inject_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;

    typedef logic [DW+1:0] ent_t;   // {is_header, is_tail, flit}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_local_inject_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    noc_local_inject_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .noc_clk (clk),
        .noc_rst (rst),
        .arb     (bus)
    );

    ent_t in_q [NR][$];
    ent_t out_q[$];
    ent_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int stall_viol = 0;

    logic [NR-1:0] fired = '0;
    logic          last_stalled = 1'b0;
    ent_t          last_out = '0;
    ent_t          cur_out;

    assign cur_out = {bus.out_is_header, bus.out_is_tail, bus.out_flit};

    // Capture handshakes and router-side transfers; watch that a stalled output holds still.
    always @(posedge clk) begin
        fired <= bus.req_valid & bus.req_ready;
        if (rst) begin
            last_stalled <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) out_q.push_back(cur_out);
            if (last_stalled && (cur_out !== last_out)) stall_viol <= stall_viol + 1;
            last_stalled <= bus.out_valid && !bus.out_ready;
            last_out     <= cur_out;
        end
    end

    // Present the head of each source queue; retire it after it was accepted.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (fired[i] && in_q[i].size() > 0) void'(in_q[i].pop_front());
            if (in_q[i].size() > 0) begin
                bus.req_valid[i]          <= 1'b1;
                bus.req_is_header[i]      <= in_q[i][0][DW+1];
                bus.req_is_tail[i]        <= in_q[i][0][DW];
                bus.req_flit[i*DW +: DW]  <= in_q[i][0][DW-1:0];
            end else begin
                bus.req_valid[i]          <= 1'b0;
                bus.req_is_header[i]      <= 1'b0;
                bus.req_is_tail[i]        <= 1'b0;
                bus.req_flit[i*DW +: DW]  <= '0;
            end
        end
    end

    function automatic logic [DW-1:0] fl(input int src, input int tag, input int k);
        return {8'(tag), 8'(src), 16'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int src, input int n, input int tag);
        for (int k = 0; k < n; k++)
            in_q[src].push_back({(k == 0), (k == n - 1), fl(src, tag, k)});
    endtask

    task automatic expect_pkt(input int src, input int n, input int tag);
        for (int k = 0; k < n; k++)
            exp_q.push_back({(k == 0), (k == n - 1), fl(src, tag, k)});
    endtask

    task automatic wait_out(input int n, input int budget, input bit rand_ready, input string tag);
        int c = 0;
        while (out_q.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            c++;
        end
        bus.out_ready = 1'b1;
        check({tag, "_arrived"}, 64'(out_q.size() >= n), 64'd1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_flit%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NR; i++) in_q[i].delete();
        out_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol_base;
        bus.out_ready = 1'b1;
        #1;
        // Reset state: {out_valid, hdr, tail, timeout_err, grant, req_ready, flit}
        check("reset_state",
              64'({bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.timeout_err,
                   bus.grant, bus.req_ready, bus.out_flit}), 64'd0);

        // 1: single 12-flit packet from req0, one bubble before the header
        do_reset();
        push_pkt(0, 12, 1);
        expect_pkt(0, 12, 1);
        @(negedge clk);
        @(negedge clk);
        check("t1_grant_arb", 64'(bus.grant), 64'b0001);
        check("t1_idle_bubble", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("t1_hdr_out", 64'(cur_out), 64'({1'b1, 1'b0, fl(0, 1, 0)}));
        check("t1_hdr_valid", 64'(bus.out_valid), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t1_grant_hold%0d", k), 64'(bus.grant), 64'b0001);
        end
        @(negedge clk);
        check("t1_grant_release", 64'(bus.grant), 64'd0);
        check("t1_tail_flag", 64'(bus.out_is_tail), 64'd1);
        wait_out(12, 100, 1'b0, "t1");
        check_seq("t1");

        // 2: four simultaneous headers, then req0/req2 alternate
        do_reset();
        for (int s = 0; s < NR; s++) push_pkt(s, 3, 2);
        for (int s = 0; s < NR; s++) expect_pkt(s, 3, 2);
        wait_out(12, 200, 1'b0, "t2a");
        check_seq("t2a");
        push_pkt(0, 2, 3);
        push_pkt(0, 2, 4);
        push_pkt(2, 2, 3);
        push_pkt(2, 2, 4);
        expect_pkt(0, 2, 3);
        expect_pkt(2, 2, 3);
        expect_pkt(0, 2, 4);
        expect_pkt(2, 2, 4);
        wait_out(8, 200, 1'b0, "t2b");
        check_seq("t2b");

        // 3: random backpressure on a 12-flit packet
        do_reset();
        viol_base = stall_viol;
        push_pkt(1, 12, 5);
        expect_pkt(1, 12, 5);
        wait_out(12, 600, 1'b1, "t3");
        check_seq("t3");
        check("t3_stall_stable", 64'(stall_viol - viol_base), 64'd0);

        // 4: single-flit packet from req1, then req2 wins over req1's next header
        do_reset();
        push_pkt(1, 1, 6);
        push_pkt(1, 3, 7);
        push_pkt(2, 3, 6);
        expect_pkt(1, 1, 6);
        expect_pkt(2, 3, 6);
        expect_pkt(1, 3, 7);
        @(negedge clk);
        @(negedge clk);
        check("t4_grant_req1", 64'(bus.grant), 64'b0010);
        @(negedge clk);
        check("t4_grant_released", 64'(bus.grant), 64'd0);
        check("t4_single_flit", 64'({bus.out_valid, cur_out}), 64'({1'b1, 1'b1, 1'b1, fl(1, 6, 0)}));
        @(negedge clk);
        check("t4_grant_req2", 64'(bus.grant), 64'b0100);
        wait_out(7, 100, 1'b0, "t4");
        check_seq("t4");

        // 5: reset in the middle of a packet, then a fresh packet from req3
        do_reset();
        push_pkt(0, 12, 8);
        wait_out(5, 100, 1'b0, "t5_pre");
        rst = 1'b1;
        #1;
        check("t5_reset_outputs",
              64'({bus.out_valid, bus.out_is_header, bus.out_is_tail, bus.timeout_err,
                   bus.grant, bus.req_ready, bus.out_flit}), 64'd0);
        do_reset();
        push_pkt(3, 3, 9);
        expect_pkt(3, 3, 9);
        @(negedge clk);
        @(negedge clk);
        check("t5_grant_req3", 64'(bus.grant), 64'b1000);
        wait_out(3, 100, 1'b0, "t5");
        check_seq("t5");

`ifdef NOC_ARB_TIMEOUT_EN
        // 6: owner stalls after its header; watchdog closes the packet, req1 proceeds
        do_reset();
        in_q[0].push_back({1'b1, 1'b0, fl(0, 10, 0)});
        push_pkt(1, 2, 10);
        exp_q.push_back({1'b1, 1'b0, fl(0, 10, 0)});
        exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
        expect_pkt(1, 2, 10);
        wait_out(4, 200, 1'b0, "t6");
        check_seq("t6");
        check("t6_timeout_err", 64'(bus.timeout_err), 64'd1);
`else
        check("no_timeout_err", 64'(bus.timeout_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
